// File: rtl/sprite_palette_pkg.sv
// -----------------------------------------------------------------------------
// sprite_palette_pkg
// Shared types and constants for the sprite palette bank.
//   rgb_t             : packed {red, green, blue} entry, 4 bits per channel,
//                       MSB-first (red in [11:8]).
//   bank_state_e      : pending-request state of the bank controller.
//   DEFAULT_PALETTE   : 16-entry sprite palette loaded into every bank on reset.
//   default_entry()   : reset value for any index; indices past 15 give 0.
// -----------------------------------------------------------------------------
package sprite_palette_pkg;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  typedef enum logic {
    BANK_IDLE    = 1'b0,
    BANK_PENDING = 1'b1
  } bank_state_e;

  localparam int unsigned DEFAULT_DEPTH = 16;

  // Index 0 is the magenta colour-key, then sprite greens, pinks and greys.
  localparam rgb_t DEFAULT_PALETTE [DEFAULT_DEPTH] = '{
    rgb_t'(12'hF0F), rgb_t'(12'h2C7), rgb_t'(12'hF8A), rgb_t'(12'h1A4),
    rgb_t'(12'h5E8), rgb_t'(12'h8AA), rgb_t'(12'hF6C), rgb_t'(12'hFCD),
    rgb_t'(12'h111), rgb_t'(12'h333), rgb_t'(12'h555), rgb_t'(12'h777),
    rgb_t'(12'h999), rgb_t'(12'hBBB), rgb_t'(12'hDDD), rgb_t'(12'hFFF)
  };

  function automatic rgb_t default_entry(input int unsigned idx);
    rgb_t entry;
    entry = '0;
    if (idx < DEFAULT_DEPTH) entry = DEFAULT_PALETTE[idx[3:0]];
    return entry;
  endfunction

endpackage

// File: rtl/palette_bank_ctrl.sv
// -----------------------------------------------------------------------------
// palette_bank_ctrl
// Holds the active palette bank and a single pending bank request. Requests
// are deferred until frame_start so a bank swap only happens in blanking.
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   frame_start_i       : one-cycle pulse at start of vertical blanking
//   bank_req_valid_i    : request strobe
//   bank_req_i          : requested bank; values >= NUM_BANKS are dropped
//   active_bank_o       : bank currently used for lookups
// -----------------------------------------------------------------------------
module palette_bank_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_start_i,
  input  logic              bank_req_valid_i,
  input  logic [BANK_W-1:0] bank_req_i,
  output logic [BANK_W-1:0] active_bank_o
);

  bank_state_e       state_q, state_d;
  logic [BANK_W-1:0] pending_q, pending_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              req_ok;

  // Out-of-range requests behave as if no request was made at all.
  assign req_ok = bank_req_valid_i && (int'(bank_req_i) < NUM_BANKS);

  // A request arriving together with frame_start bypasses the pending
  // register and takes effect at once, leaving nothing pending.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (frame_start_i) begin
      if (req_ok) begin
        active_d = bank_req_i;
      end else if (state_q == BANK_PENDING) begin
        active_d = pending_q;
      end
      state_d = BANK_IDLE;
    end else if (req_ok) begin
      pending_d = bank_req_i;
      state_d   = BANK_PENDING;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= BANK_IDLE;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign active_bank_o = active_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// -----------------------------------------------------------------------------
// sprite_palette_bank
// Multi-bank colour palette for sprite pixels with a fixed 2-cycle lookup.
//   Clk, Reset_n                 : clock, synchronous active-low reset
//   frame_start                  : blanking pulse; applies a pending bank swap
//   bank_req_valid, bank_req     : bank switch request
//   wr_en, wr_bank, wr_idx, wr_rgb : palette write port ({r,g,b} MSB-first)
//   pix_valid_in, pix_idx        : incoming pixel colour indices
//   pix_valid_out, red, green, blue, transp : looked-up pixel (0 when invalid)
//   active_bank                  : bank used for new lookups
// -----------------------------------------------------------------------------
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int CH_W       = 4,
  parameter int NUM_BANKS  = 4,
  parameter int TRANSP_IDX = 0,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              bank_req_valid,
  input  logic [BANK_W-1:0] bank_req,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              pix_valid_in,
  input  logic [IDX_W-1:0]  pix_idx,
  output logic              pix_valid_out,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transp,
  output logic [BANK_W-1:0] active_bank
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int RGB_W = 3 * CH_W;

  logic [RGB_W-1:0]  pal_q [NUM_BANKS][DEPTH];
  logic [BANK_W-1:0] active_bank_w;

  logic              s1_valid_q;
  logic [IDX_W-1:0]  s1_idx_q;
  logic [BANK_W-1:0] s1_bank_q;

  logic              out_valid_q;
  logic [RGB_W-1:0]  out_rgb_q;
  logic              out_transp_q;

  palette_bank_ctrl #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_ctrl (
    .clk_i            (Clk),
    .rst_ni           (Reset_n),
    .frame_start_i    (frame_start),
    .bank_req_valid_i (bank_req_valid),
    .bank_req_i       (bank_req),
    .active_bank_o    (active_bank_w)
  );

  // Palette storage. The stage-2 read below samples pal_q before this edge's
  // write lands, so a same-cycle write to the entry being read yields the
  // old colour and the new one is seen from the following read.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          pal_q[b][i] <= RGB_W'(default_entry(i));
        end
      end
    end else if (wr_en && (int'(wr_bank) < NUM_BANKS)) begin
      pal_q[wr_bank][wr_idx] <= wr_rgb;
    end
  end

  // Stage 1 captures the bank alongside the index so a bank swap never
  // affects a pixel that is already in flight.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_bank_q    <= '0;
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_transp_q <= 1'b0;
    end else begin
      s1_valid_q  <= pix_valid_in;
      s1_idx_q    <= pix_idx;
      s1_bank_q   <= active_bank_w;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_rgb_q    <= pal_q[s1_bank_q][s1_idx_q];
        out_transp_q <= (s1_idx_q == IDX_W'(TRANSP_IDX));
      end else begin
        out_rgb_q    <= '0;
        out_transp_q <= 1'b0;
      end
    end
  end

  assign pix_valid_out = out_valid_q;
  assign red           = out_rgb_q[RGB_W-1 -: CH_W];
  assign green         = out_rgb_q[2*CH_W-1 -: CH_W];
  assign blue          = out_rgb_q[CH_W-1:0];
  assign transp        = out_transp_q;
  assign active_bank   = active_bank_w;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// -----------------------------------------------------------------------------
// tb_sprite_palette_bank
// Self-checking bench for sprite_palette_bank (default parameters) plus a
// second 3-bank instance used to exercise out-of-range bank requests.
// -----------------------------------------------------------------------------
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frameStart, bankReqValid, wrEn, pixValidIn;
  logic [1:0]  bankReq, wrBank;
  logic [3:0]  wrIdx, pixIdx;
  logic [11:0] wrRgb;
  logic        pixValidOut, transp;
  logic [3:0]  red, green, blue;
  logic [1:0]  activeBank;

  logic        n3FrameStart, n3ReqValid;
  logic [1:0]  n3Req;
  logic        n3PixValid, n3Transp;
  logic [3:0]  n3Red, n3Green, n3Blue;
  logic [1:0]  n3ActiveBank;

  always #5 Clk = ~Clk;

  sprite_palette_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frameStart),
    .bank_req_valid(bankReqValid), .bank_req(bankReq),
    .wr_en(wrEn), .wr_bank(wrBank), .wr_idx(wrIdx), .wr_rgb(wrRgb),
    .pix_valid_in(pixValidIn), .pix_idx(pixIdx),
    .pix_valid_out(pixValidOut), .red(red), .green(green), .blue(blue),
    .transp(transp), .active_bank(activeBank)
  );

  sprite_palette_bank #(.NUM_BANKS(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(n3FrameStart),
    .bank_req_valid(n3ReqValid), .bank_req(n3Req),
    .wr_en(1'b0), .wr_bank(2'd0), .wr_idx(4'd0), .wr_rgb(12'h000),
    .pix_valid_in(1'b0), .pix_idx(4'd0),
    .pix_valid_out(n3PixValid), .red(n3Red), .green(n3Green), .blue(n3Blue),
    .transp(n3Transp), .active_bank(n3ActiveBank)
  );

  typedef struct {
    logic        pv;
    logic [3:0]  pidx;
    logic        wr;
    logic [1:0]  wb;
    logic [3:0]  wi;
    logic [11:0] wrgb;
    logic        rq;
    logic [1:0]  rb;
    logic        fs;
    logic        eValid;
    logic [11:0] eRgb;
    logic        eTransp;
    logic [1:0]  eBank;
  } vec_t;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: palette contents, active bank, optional pending bank,
  // and the pixel accepted last cycle (looked up one cycle later).
  logic [11:0] defPal [16];
  logic [11:0] mPal [4][16];
  int          mActive, mPending;
  logic        mHistValid;
  int          mHistIdx, mHistBank;
  logic        expValid, expTransp;
  logic [11:0] expRgb;

  vec_t tbl [11];
  vec_t idle;

  function automatic vec_t mk(input logic pv, input logic [3:0] pidx,
                              input logic wr, input logic [1:0] wb,
                              input logic [3:0] wi, input logic [11:0] wrgb,
                              input logic rq, input logic [1:0] rb,
                              input logic fs);
    vec_t v;
    v = '{default: '0};
    v.pv = pv; v.pidx = pidx; v.wr = wr; v.wb = wb; v.wi = wi;
    v.wrgb = wrgb; v.rq = rq; v.rb = rb; v.fs = fs;
    return v;
  endfunction

  function automatic vec_t withExp(input vec_t vin, input logic ev,
                                   input logic [11:0] ergb, input logic et,
                                   input logic [1:0] eb);
    vec_t v;
    v = vin;
    v.eValid = ev; v.eRgb = ergb; v.eTransp = et; v.eBank = eb;
    return v;
  endfunction

  task automatic modelStep(input vec_t v, input logic rstn);
    if (!rstn) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 16; i++) mPal[b][i] = defPal[i];
      mActive = 0; mPending = -1;
      mHistValid = 1'b0; mHistIdx = 0; mHistBank = 0;
      expValid = 1'b0; expRgb = 12'h000; expTransp = 1'b0;
    end else begin
      expValid  = mHistValid;
      expRgb    = mHistValid ? mPal[mHistBank][mHistIdx] : 12'h000;
      expTransp = mHistValid && (mHistIdx == 0);
      mHistValid = v.pv; mHistIdx = int'(v.pidx); mHistBank = mActive;
      if (v.wr) mPal[v.wb][v.wi] = v.wrgb;
      if (v.fs) begin
        if (v.rq) mActive = int'(v.rb);
        else if (mPending >= 0) mActive = mPending;
        mPending = -1;
      end else if (v.rq) begin
        mPending = int'(v.rb);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pixValidIn = v.pv; pixIdx = v.pidx;
    wrEn = v.wr; wrBank = v.wb; wrIdx = v.wi; wrRgb = v.wrgb;
    bankReqValid = v.rq; bankReq = v.rb; frameStart = v.fs;
    modelStep(v, Reset_n);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev,
                             input logic [11:0] ergb, input logic et,
                             input logic [1:0] eb);
    testsRun++;
    if ({pixValidOut, red, green, blue, transp, activeBank} !== {ev, ergb, et, eb}) begin
      testsFailed++;
      $display("[TB] FAIL %s: got v=%0b rgb=%h t=%0b bank=%0d, want v=%0b rgb=%h t=%0b bank=%0d",
               name, pixValidOut, {red, green, blue}, transp, activeBank, ev, ergb, et, eb);
    end
  endtask

  task automatic checkBank(input string name, input logic [1:0] actual,
                           input logic [1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got bank=%0d, want bank=%0d", name, actual, expected);
    end
  endtask

  initial begin
    defPal = '{12'hF0F, 12'h2C7, 12'hF8A, 12'h1A4, 12'h5E8, 12'h8AA, 12'hF6C, 12'hFCD,
               12'h111, 12'h333, 12'h555, 12'h777, 12'h999, 12'hBBB, 12'hDDD, 12'hFFF};
    idle = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    n3FrameStart = 1'b0; n3ReqValid = 1'b0; n3Req = 2'd0;

    // Vectors: expected outputs are those visible just after that cycle's edge.
    tbl[0]  = withExp(mk(1, 4'd0, 0, 0, 0, 12'h000, 0, 0, 0), 0, 12'h000, 0, 0);
    tbl[1]  = withExp(mk(1, 4'd1, 0, 0, 0, 12'h000, 0, 0, 0), 1, 12'hF0F, 1, 0);
    tbl[2]  = withExp(mk(1, 4'd2, 0, 0, 0, 12'h000, 0, 0, 0), 1, 12'h2C7, 0, 0);
    tbl[3]  = withExp(mk(0, 4'd0, 1, 1, 3, 12'h123, 0, 0, 0), 1, 12'hF8A, 0, 0);
    tbl[4]  = withExp(mk(0, 4'd0, 0, 0, 0, 12'h000, 1, 1, 0), 0, 12'h000, 0, 0);
    tbl[5]  = withExp(mk(0, 4'd0, 0, 0, 0, 12'h000, 0, 0, 1), 0, 12'h000, 0, 1);
    tbl[6]  = withExp(mk(1, 4'd3, 0, 0, 0, 12'h000, 0, 0, 0), 0, 12'h000, 0, 1);
    tbl[7]  = withExp(mk(1, 4'd3, 0, 0, 0, 12'h000, 1, 0, 0), 1, 12'h123, 0, 1);
    tbl[8]  = withExp(mk(0, 4'd0, 0, 0, 0, 12'h000, 0, 0, 1), 1, 12'h123, 0, 0);
    tbl[9]  = withExp(mk(1, 4'd3, 0, 0, 0, 12'h000, 0, 0, 0), 0, 12'h000, 0, 0);
    tbl[10] = withExp(mk(0, 4'd0, 0, 0, 0, 12'h000, 0, 0, 0), 1, 12'h1A4, 0, 0);

    Reset_n = 1'b0;
    applyStimulus(idle);
    applyStimulus(idle);
    checkOutput("reset state", 0, 12'h000, 0, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vector %0d", i), tbl[i].eValid, tbl[i].eRgb,
                  tbl[i].eTransp, tbl[i].eBank);
    end

    // Last request wins; simultaneous request+frame_start is immediate.
    applyStimulus(mk(0, 0, 0, 0, 0, 12'h000, 1, 2, 0));
    checkBank("pending not applied", activeBank, 2'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 12'h000, 1, 3, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 1));
    checkBank("last request wins", activeBank, 2'd3);
    applyStimulus(mk(0, 0, 0, 0, 0, 12'h000, 1, 1, 1));
    checkBank("request with frame_start", activeBank, 2'd1);
    applyStimulus(mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 1));
    checkBank("no pending after bypass", activeBank, 2'd1);

    // Write to the entry being read in the same cycle.
    applyStimulus(mk(1, 4'd5, 0, 0, 0, 12'h000, 0, 0, 0));
    applyStimulus(mk(1, 4'd5, 1, 1, 5, 12'hABC, 0, 0, 0));
    checkOutput("write collision old", 1, 12'h8AA, 0, 1);
    applyStimulus(idle);
    checkOutput("write collision new", 1, 12'hABC, 0, 1);

    // Reset mid-stream with a write and a request presented during reset.
    applyStimulus(mk(1, 4'd5, 1, 0, 0, 12'h000, 0, 0, 0));
    Reset_n = 1'b0;
    applyStimulus(mk(1, 4'd5, 1, 0, 0, 12'h777, 1, 3, 0));
    checkOutput("reset flushes output", 0, 12'h000, 0, 0);
    applyStimulus(mk(1, 4'd5, 1, 0, 0, 12'h777, 1, 3, 0));
    checkOutput("held in reset", 0, 12'h000, 0, 0);
    Reset_n = 1'b1;
    applyStimulus(mk(1, 4'd0, 0, 0, 0, 12'h000, 0, 0, 0));
    checkOutput("post-reset gap", 0, 12'h000, 0, 0);
    applyStimulus(mk(1, 4'd0, 0, 0, 0, 12'h000, 0, 0, 1));
    checkOutput("default restored", 1, 12'hF0F, 1, 0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 3) == 0),
             2'($urandom), 4'($urandom), 12'($urandom), 1'($urandom_range(0, 7) == 0),
             2'($urandom), 1'($urandom_range(0, 15) == 0));
      Reset_n = ($urandom_range(0, 99) != 0);
      applyStimulus(v);
      checkOutput("random", expValid, expRgb, expTransp, 2'(mActive));
    end
    Reset_n = 1'b1;
    applyStimulus(idle);

    // Out-of-range request on the 3-bank instance.
    n3ReqValid = 1'b1; n3Req = 2'd3;
    applyStimulus(idle);
    n3ReqValid = 1'b0; n3FrameStart = 1'b1;
    applyStimulus(idle);
    checkBank("n3 out-of-range ignored", n3ActiveBank, 2'd0);
    n3FrameStart = 1'b0; n3ReqValid = 1'b1; n3Req = 2'd2;
    applyStimulus(idle);
    n3Req = 2'd3;
    applyStimulus(idle);
    n3ReqValid = 1'b0; n3FrameStart = 1'b1;
    applyStimulus(idle);
    checkBank("n3 pending survives bad request", n3ActiveBank, 2'd2);
    n3FrameStart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
